// File: rtl/result_bcd_display.sv
// Captures 8-bit products, converts them to 3-digit BCD with a double-dabble FSM and
// drives a multiplexed 4-digit common-anode display. Optional macro: STATE_DIGIT_EN.
module result_bcd_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit LEADING_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  result,
  input  logic        result_valid,
  input  logic [2:0]  st_in,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    BLANK   = 7'b1111111;

  // Handshake: result is taken on any cycle result_valid is high; there is no ready.
  // While busy the value lands in a one-deep pending slot (newest wins).
  state_e        state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [11:0]   adj;
  logic [3:0]    count_q, count_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_q, pend_d;
  logic [11:0]   bcd_q, bcd_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    scratch_d    = scratch_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    bcd_d        = bcd_q;
    case (state_q)
      IDLE: begin
        if (result_valid) begin
          bin_d     = result;
          scratch_d = 12'd0;
          count_d   = 4'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adj[10:0], bin_q, 1'b0};
        count_d            = count_q + 4'd1;
        if (count_q == 4'd7) state_d = DONE;
        if (result_valid) begin
          pend_valid_d = 1'b1;
          pend_d       = result;
        end
      end
      DONE: begin
        bcd_d        = scratch_q;
        pend_valid_d = 1'b0;
        scratch_d    = 12'd0;
        count_d      = 4'd0;
        // A strobe on this edge is newer than anything already pending.
        if (result_valid) begin
          bin_d   = result;
          state_d = SHIFT;
        end else if (pend_valid_q) begin
          bin_d   = pend_q;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    digit_d = digit_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
    an_d = ~(4'b0001 << digit_d);
    case (digit_d)
      2'd0:    seg_d = seg_of(bcd_d[3:0]);
      2'd1:    seg_d = (LEADING_BLANK && bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0)
                       ? BLANK : seg_of(bcd_d[7:4]);
      2'd2:    seg_d = (LEADING_BLANK && bcd_d[11:8] == 4'd0) ? BLANK : seg_of(bcd_d[11:8]);
`ifdef STATE_DIGIT_EN
      default: seg_d = seg_of({1'b0, st_in});
`else
      default: seg_d = BLANK;
`endif
    endcase
  end

`ifndef STATE_DIGIT_EN
  logic unused_st_in;
  assign unused_st_in = ^st_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bin_q        <= 8'd0;
      scratch_q    <= 12'd0;
      count_q      <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_q       <= 8'd0;
      bcd_q        <= 12'd0;
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      an_q         <= 4'b1110;
      seg_q        <= 7'b1000000;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      scratch_q    <= scratch_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign bcd_out   = bcd_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: two instances (leading blank on/off) share stimulus.
module tb_result_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        result_valid;
  logic [7:0]  result;
  logic [2:0]  st_in;

  logic        busy_lb, busy_nb, dp_lb, dp_nb;
  logic [11:0] bcd_lb, bcd_nb;
  logic [6:0]  seg_lb, seg_nb;
  logic [3:0]  an_lb, an_nb;
  logic [1:0]  st_lb, st_nb;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  result_bcd_display #(.REFRESH_DIV(4), .LEADING_BLANK(1'b1)) dut_lb (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid), .st_in(st_in),
    .busy(busy_lb), .bcd_out(bcd_lb), .seg(seg_lb), .an(an_lb), .dp(dp_lb),
    .dbg_state(st_lb)
  );

  result_bcd_display #(.REFRESH_DIV(4), .LEADING_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid), .st_in(st_in),
    .busy(busy_nb), .bcd_out(bcd_nb), .seg(seg_nb), .an(an_nb), .dp(dp_nb),
    .dbg_state(st_nb)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Strobe v and follow the conversion through its 9-edge latency.
  task automatic conv(input logic [7:0] v, input logic [11:0] old_bcd,
                      input logic [11:0] new_bcd, input string tag);
    @(negedge clk);
    result       = v;
    result_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) result_valid = 1'b0;
      if (i <= 9) chk({tag, "_busy"}, {15'd0, busy_lb}, 16'd1);
      if (i == 9) chk({tag, "_bcd_early"}, {4'd0, bcd_lb}, {4'd0, old_bcd});
      if (i == 10) begin
        chk({tag, "_bcd"}, {4'd0, bcd_lb}, {4'd0, new_bcd});
        chk({tag, "_bcd_nb"}, {4'd0, bcd_nb}, {4'd0, new_bcd});
        chk({tag, "_idle"}, {15'd0, busy_lb}, 16'd0);
      end
    end
  endtask

  task automatic show(input logic [3:0] an_want, input logic [6:0] exp_lb,
                      input logic [6:0] exp_nb, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an_lb === an_want) found = 1'b1;
    end
    chk({tag, "_an_seen"}, {15'd0, found}, 16'd1);
    if (found) begin
      chk({tag, "_seg_lb"}, {9'd0, seg_lb}, {9'd0, exp_lb});
      chk({tag, "_seg_nb"}, {9'd0, seg_nb}, {9'd0, exp_nb});
    end
  endtask

  initial begin
    logic [1:0] d;
    rst          = 1'b0;
    result_valid = 1'b0;
    result       = 8'd0;
    st_in        = 3'd5;
    repeat (2) @(negedge clk);
    chk("rst_bcd", {4'd0, bcd_lb}, 16'h0000);
    chk("rst_busy", {15'd0, busy_lb}, 16'd0);
    chk("rst_an", {12'd0, an_lb}, 16'b1110);
    chk("rst_seg", {9'd0, seg_lb}, {9'd0, S0});
    chk("rst_dp", {15'd0, dp_lb}, 16'd1);

    // Refresh walk: each digit lit for 4 clocks.
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      d = 2'((i / 4) % 4);
      chk("walk_an", {12'd0, an_lb}, {12'd0, ~(4'b0001 << d)});
      chk("walk_seg_lb", {9'd0, seg_lb}, {9'd0, (d == 2'd0) ? S0 : SB});
      chk("walk_seg_nb", {9'd0, seg_nb}, {9'd0, (d == 2'd3) ? SB : S0});
    end

    conv(8'd255, 12'h000, 12'h255, "c255");
    show(4'b1110, S5, S5, "c255_d0");
    show(4'b1101, S5, S5, "c255_d1");
    show(4'b1011, S2, S2, "c255_d2");
    show(4'b0111, SB, SB, "c255_d3");

    conv(8'd0, 12'h255, 12'h000, "c0");
    conv(8'd9, 12'h000, 12'h009, "c9");
    show(4'b1110, S9, S9, "c9_d0");
    show(4'b1101, SB, S0, "c9_d1");
    show(4'b1011, SB, S0, "c9_d2");

    // Back-to-back: 12, then 200 at +3 overwritten by 7 at +5.
    @(negedge clk);
    result       = 8'd12;
    result_valid = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i <= 18) chk("b2b_busy", {15'd0, busy_lb}, 16'd1);
      if (i == 10) chk("b2b_first", {4'd0, bcd_lb}, 16'h0012);
      if (i == 19) begin
        chk("b2b_second", {4'd0, bcd_lb}, 16'h0007);
        chk("b2b_idle", {15'd0, busy_lb}, 16'd0);
      end
      result_valid = (i == 3) || (i == 5);
      result       = (i == 3) ? 8'd200 : 8'd7;
    end
    show(4'b1110, S7, S7, "b2b_d0");

    // Reset during SHIFT step 4 of 137.
    @(negedge clk);
    result       = 8'd137;
    result_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) result_valid = 1'b0;
      if (i == 4) rst = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", {15'd0, busy_lb}, 16'd0);
    chk("abort_bcd", {4'd0, bcd_lb}, 16'h0000);
    chk("abort_an", {12'd0, an_lb}, 16'b1110);
    chk("abort_seg", {9'd0, seg_lb}, {9'd0, S0});
    rst = 1'b1;
    conv(8'd100, 12'h000, 12'h100, "c100");
    show(4'b1011, S1, S1, "c100_d2");
    show(4'b1101, S0, S0, "c100_d1");

    // Strobe landing exactly on the DONE edge starts the next conversion at once.
    @(negedge clk);
    result       = 8'd42;
    result_valid = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i <= 18) chk("done_edge_busy", {15'd0, busy_lb}, 16'd1);
      if (i == 10) chk("done_edge_first", {4'd0, bcd_lb}, 16'h0042);
      if (i == 19) chk("done_edge_second", {4'd0, bcd_lb}, 16'h0099);
      result_valid = (i == 9);
      result       = 8'd99;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
